// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg -- shared definitions for the traffic light controller.
//
// Holds the controller state encodings, the lamp patterns ({red,yellow,green}),
// the default phase durations, and a helper that maps a state plus the night
// flash bit onto the lamp pair for both roads.
// ---------------------------------------------------------------------------
package tl_pkg;

    // Controller states. Kept as plain 3-bit constants so the encoding is
    // visible on the phase output exactly as listed here.
    localparam logic [2:0] S_MG = 3'd0;  // main green
    localparam logic [2:0] S_MY = 3'd1;  // main yellow
    localparam logic [2:0] S_R1 = 3'd2;  // all red, main -> side
    localparam logic [2:0] S_SG = 3'd3;  // side green
    localparam logic [2:0] S_SY = 3'd4;  // side yellow
    localparam logic [2:0] S_R2 = 3'd5;  // all red, side -> main
    localparam logic [2:0] S_NT = 3'd6;  // night flashing yellow

    // Lamp patterns, bit order {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Default phase durations in ticks.
    localparam int unsigned DEF_T_MAIN_G = 30;
    localparam int unsigned DEF_T_SIDE_G = 20;
    localparam int unsigned DEF_T_YEL    = 3;
    localparam int unsigned DEF_T_RED    = 1;

    typedef struct packed {
        logic [2:0] main_lt;
        logic [2:0] side_lt;
    } lamps_t;

    // Lamp pair for a state. In night mode only the yellows are lit, and
    // both follow the flash bit.
    function automatic lamps_t state_lamps(input logic [2:0] st, input logic flash);
        lamps_t l;
        l = '{main_lt: RED, side_lt: RED};
        case (st)
            S_MG:    l = '{main_lt: GRN, side_lt: RED};
            S_MY:    l = '{main_lt: YEL, side_lt: RED};
            S_SG:    l = '{main_lt: RED, side_lt: GRN};
            S_SY:    l = '{main_lt: RED, side_lt: YEL};
            S_NT:    l = '{main_lt: (flash ? YEL : OFF), side_lt: (flash ? YEL : OFF)};
            default: l = '{main_lt: RED, side_lt: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_timer.sv
// ---------------------------------------------------------------------------
// tl_timer -- loadable phase countdown.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset, count returns to RST_VAL
//   tick      timebase strobe, decrements the count by one
//   load      load load_val (wins over a simultaneous tick)
//   load_val  value to load
//   cnt       current count (registered)
//   expire    tick on the last tick of the phase (cnt == 1)
// ---------------------------------------------------------------------------
module tl_timer #(
    parameter int unsigned CW      = 8,
    parameter int unsigned RST_VAL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          expire
);

    logic [CW-1:0] cnt_q;

    // NOTE: state registers are written with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(RST_VAL);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cnt    = cnt_q;
    assign expire = tick & (cnt_q == CW'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl -- two-road intersection controller.
//
// Main road rests in green and only yields when a side-road request is
// pending at the end of a main-green period. Every hand-over passes through
// yellow and an all-red clearance. A night request switches both roads to a
// flashing yellow; leaving night mode always goes through all-red first.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset (highest priority)
//   tick      one-cycle timebase strobe
//   side_req  side-road vehicle sensor (level or pulse, latched)
//   night     flashing-yellow mode request (level)
//   main_lt   main-road lamps {red,yellow,green}, registered
//   side_lt   side-road lamps {red,yellow,green}, registered
//   remain    ticks left in the current phase (0 in night mode)
//   phase     current state encoding
// ---------------------------------------------------------------------------
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned T_MAIN_G = DEF_T_MAIN_G,
    parameter int unsigned T_SIDE_G = DEF_T_SIDE_G,
    parameter int unsigned T_YEL    = DEF_T_YEL,
    parameter int unsigned T_RED    = DEF_T_RED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          side_req,
    input  logic          night,
    output logic [2:0]    main_lt,
    output logic [2:0]    side_lt,
    output logic [CW-1:0] remain,
    output logic [2:0]    phase
);

    // Durations must be non-zero and representable in the countdown.
    localparam longint unsigned CNT_LIMIT = longint'(1) << CW;

    if (T_MAIN_G < 1 || longint'(T_MAIN_G) >= CNT_LIMIT ||
        T_SIDE_G < 1 || longint'(T_SIDE_G) >= CNT_LIMIT ||
        T_YEL    < 1 || longint'(T_YEL)    >= CNT_LIMIT ||
        T_RED    < 1 || longint'(T_RED)    >= CNT_LIMIT) begin : g_bad_duration
        $error("traffic_light_ctrl: every duration must be >= 1 and < 2**CW");
    end

    logic [2:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic          flash_q, flash_d;
    logic [2:0]    main_lt_q, side_lt_q;
    lamps_t        lamps_d;

    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] cnt;
    logic          expire;

    tl_timer #(
        .CW      (CW),
        .RST_VAL (T_RED)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .expire   (expire)
    );

    // Next-state logic. Night has priority over expiry; inside night mode the
    // countdown is reloaded with 0 every cycle so it holds there.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        pending_d = pending_q | side_req;
        flash_d   = flash_q;
        load      = 1'b0;
        load_val  = '0;

        if (state_q != S_NT && night) begin
            state_d = S_NT;
            flash_d = 1'b1;
            load    = 1'b1;
        end else if (state_q == S_NT) begin
            load = 1'b1;
            if (!night) begin
                state_d  = S_R2;
                load_val = CW'(T_RED);
            end else if (tick) begin
                flash_d = ~flash_q;
            end
        end else if (expire) begin
            load = 1'b1;
            case (state_q)
                S_MG: begin
                    // A request arriving on the expiry cycle itself counts.
                    if (pending_d) begin
                        state_d  = S_MY;
                        load_val = CW'(T_YEL);
                    end else begin
                        load_val = CW'(T_MAIN_G);
                    end
                end
                S_MY: begin
                    state_d  = S_R1;
                    load_val = CW'(T_RED);
                end
                S_R1: begin
                    state_d   = S_SG;
                    load_val  = CW'(T_SIDE_G);
                    pending_d = 1'b0;
                end
                S_SG: begin
                    state_d  = S_SY;
                    load_val = CW'(T_YEL);
                end
                S_SY: begin
                    state_d  = S_R2;
                    load_val = CW'(T_RED);
                end
                default: begin
                    state_d  = S_MG;
                    load_val = CW'(T_MAIN_G);
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they are registered alongside
    // it and change on the same edge.
    assign lamps_d = state_lamps(state_d, flash_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_R2;
            pending_q <= 1'b0;
            flash_q   <= 1'b0;
            main_lt_q <= RED;
            side_lt_q <= RED;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            flash_q   <= flash_d;
            main_lt_q <= lamps_d.main_lt;
            side_lt_q <= lamps_d.side_lt;
        end
    end

    assign main_lt = main_lt_q;
    assign side_lt = side_lt_q;
    assign remain  = cnt;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl -- self-checking bench for traffic_light_ctrl.
//
// A behavioural model tracks (phase, ticks left, pending, flash) from table
// lookups of durations and successors; a negedge process compares every DUT
// output against it each cycle. Directed sequences pin the model with
// hand-computed literals, then randomized stimulus runs against the model.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b1;
    logic          side_req = 1'b0;
    logic          night = 1'b0;
    logic [2:0]    main_lt, side_lt, phase;
    logic [CW-1:0] remain;

    traffic_light_ctrl #(
        .CW       (CW),
        .T_MAIN_G (4),
        .T_SIDE_G (3),
        .T_YEL    (2),
        .T_RED    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .side_req (side_req),
        .night    (night),
        .main_lt  (main_lt),
        .side_lt  (side_lt),
        .remain   (remain),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 MG,1 MY,2 R1,3 SG,4 SY,5 R2,6 NT. Duration and successor of
    // each timed phase are plain table lookups.
    int dur  [6] = '{4, 2, 1, 3, 2, 1};
    int succ [6] = '{1, 2, 3, 4, 5, 0};

    int m_ph    = 5;
    int m_rem   = 1;
    bit m_pend  = 0;
    bit m_flash = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit pend_now;
        if (rst) begin
            m_ph = 5; m_rem = 1; m_pend = 0; m_flash = 0; m_valid = 1;
        end else begin
            pend_now = m_pend | side_req;
            if (m_ph != 6 && night) begin
                m_ph = 6; m_rem = 0; m_flash = 1;
            end else if (m_ph == 6) begin
                if (!night) begin
                    m_ph = 5; m_rem = dur[5];
                end else if (tick) begin
                    m_flash = !m_flash;
                end
            end else if (tick) begin
                if (m_rem == 1) begin
                    if (m_ph == 0 && !pend_now) begin
                        m_rem = dur[0];
                    end else begin
                        if (m_ph == 2) pend_now = 0;
                        m_ph  = succ[m_ph];
                        m_rem = dur[m_ph];
                    end
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            m_pend = pend_now;
        end
    end

    function automatic logic [5:0] model_lamps(input int ph, input bit fl);
        case (ph)
            0:       return {3'b001, 3'b100};
            1:       return {3'b010, 3'b100};
            3:       return {3'b100, 3'b001};
            4:       return {3'b100, 3'b010};
            6:       return fl ? {3'b010, 3'b010} : 6'b000000;
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            logic [5:0] exp_l;
            bit         clash;
            exp_l = model_lamps(m_ph, m_flash);
            check("phase",   32'(phase),   32'(m_ph));
            check("remain",  32'(remain),  32'(m_rem));
            check("main_lt", 32'(main_lt), 32'(exp_l[5:3]));
            check("side_lt", 32'(side_lt), 32'(exp_l[2:0]));
            // Green/yellow never on both roads, except night flashing.
            clash = (main_lt[1:0] != 2'b00) && (side_lt[1:0] != 2'b00) && (phase != 3'd6);
            check("no_conflict", 32'(clash), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit t, input bit s, input bit n);
        rst = r; tick = t; side_req = s; night = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_lit(input string name, input int ph, input int rem,
                              input logic [2:0] ml, input logic [2:0] sl);
        check({name, ".phase"},  32'(phase),   32'(ph));
        check({name, ".remain"}, 32'(remain),  32'(rem));
        check({name, ".main"},   32'(main_lt), 32'(ml));
        check({name, ".side"},   32'(side_lt), 32'(sl));
    endtask

    initial begin
        // Reset, with night and side_req asserted to show reset wins.
        rst = 1; tick = 1; side_req = 1; night = 1;
        @(posedge clk); @(negedge clk);
        cyc(1, 1, 0, 0);
        expect_lit("reset", 5, 1, 3'b100, 3'b100);

        // No request: R2 for one tick, then MG repeating 4,3,2,1.
        cyc(0, 1, 0, 0);
        expect_lit("mg_entry", 0, 4, 3'b001, 3'b100);
        repeat (3) cyc(0, 1, 0, 0);
        expect_lit("mg_last", 0, 1, 3'b001, 3'b100);
        cyc(0, 1, 0, 0);
        expect_lit("mg_reload", 0, 4, 3'b001, 3'b100);

        // One-cycle side request mid-MG.
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        expect_lit("my_entry", 1, 2, 3'b010, 3'b100);
        repeat (2) cyc(0, 1, 0, 0);
        expect_lit("r1_entry", 2, 1, 3'b100, 3'b100);
        cyc(0, 1, 0, 0);
        expect_lit("sg_entry", 3, 3, 3'b100, 3'b001);
        repeat (2) cyc(0, 1, 0, 0);
        expect_lit("sg_last", 3, 1, 3'b100, 3'b001);

        // Night on the SG expiry cycle: NT, not SY.
        cyc(0, 1, 0, 1);
        expect_lit("nt_entry", 6, 0, 3'b010, 3'b010);
        cyc(0, 1, 0, 1);
        expect_lit("nt_flash0", 6, 0, 3'b000, 3'b000);
        cyc(0, 1, 0, 1);
        expect_lit("nt_flash1", 6, 0, 3'b010, 3'b010);
        cyc(0, 1, 0, 0);
        expect_lit("nt_exit", 5, 1, 3'b100, 3'b100);
        cyc(0, 1, 0, 0);
        expect_lit("back_mg", 0, 4, 3'b001, 3'b100);
        // Pending was cleared on SG entry: MG simply reloads.
        repeat (4) cyc(0, 1, 0, 0);
        expect_lit("pend_clr", 0, 4, 3'b001, 3'b100);

        // Reset in SG: immediate all-red, no yellow completion.
        cyc(0, 1, 1, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                if (m_ph == 3) seen = 1;
                else cyc(0, 1, 0, 0);
            end
            check("wait_sg", 32'(seen), 32'd1);
        end
        check("in_sg.side", 32'(side_lt), 32'(3'b001));
        cyc(1, 1, 0, 0);
        expect_lit("rst_in_sg", 5, 1, 3'b100, 3'b100);

        // Tick every 5th cycle with a request: durations stretch 5x.
        for (int i = 0; i < 150; i++) cyc(0, (i % 5) == 0, (i == 20), 0);

        // Side request held high: full cycle repeats.
        for (int i = 0; i < 120; i++) cyc(0, 1, 1, 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, t, s;
            r = ($urandom_range(0, 199) == 0);
            t = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) night = !night;
            cyc(r, t, s, night);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
